// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-side memory path: bus widths, the default
// RAM base address and the response word carried through the read latency pipeline.
package cpu_mem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1c00_0000;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rd_resp_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// EX-stage data SRAM port plus the responder's status outputs. The EX side is the
// master; the responder is the slave.
interface data_sram_responder_if;
    import cpu_mem_pkg::*;

    logic              data_sram_en;
    logic [STRB_W-1:0] data_sram_we;
    logic [31:0]       data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              rdata_valid;
    logic              access_err;
    logic [31:0]       load_cnt;
    logic [31:0]       store_cnt;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, rdata_valid, access_err, load_cnt, store_cnt
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, rdata_valid, access_err, load_cnt, store_cnt
    );

endinterface

// File: rtl/sram_byte_we_array.sv
// Single-port synchronous RAM with per-byte write enables and read-first output
// register. No reset so it maps onto block RAM.
module sram_byte_we_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data RAM responder for the EX-stage SRAM port: address decode against BASE_ADDR,
// fixed-latency load return pipeline, range error flag and load/store counters.
module data_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  bus
);

    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_req_ld;
    logic                  w_req_st;
    logic                  w_unused_ok;
    logic [DATA_W-1:0]     w_ram_q;

    logic                  r_s0_vld;
    logic                  r_s0_err;
    logic [DATA_W-1:0]     r_rdata;
    logic [31:0]           r_load_cnt;
    logic [31:0]           r_store_cnt;

    rd_resp_t              w_s0;
    rd_resp_t              w_out;

    assign w_offset    = bus.data_sram_addr - BASE_ADDR;
    assign w_in_range  = (w_offset[31:ADDR_WIDTH+2] == '0);
    assign w_idx       = w_offset[ADDR_WIDTH+1:2];
    assign w_unused_ok = ^w_offset[1:0];

    assign w_req_ld = bus.data_sram_en && (bus.data_sram_we == '0);
    assign w_req_st = bus.data_sram_en && (bus.data_sram_we != '0);

    // Out-of-range requests never touch the array, so stores there are dropped.
    sram_byte_we_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (bus.data_sram_en && w_in_range),
        .i_we    (bus.data_sram_we),
        .i_addr  (w_idx),
        .i_wdata (bus.data_sram_wdata),
        .o_rdata (w_ram_q)
    );

    // Stage 0 is the RAM output register itself; only its tags need flops here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_vld <= 1'b0;
            r_s0_err <= 1'b0;
        end else begin
            r_s0_vld <= w_req_ld;
            r_s0_err <= bus.data_sram_en && !w_in_range;
        end
    end

    assign w_s0 = {r_s0_vld, r_s0_err, (r_s0_err ? {DATA_W{1'b0}} : w_ram_q)};

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign w_out = w_s0;
        end else begin : g_latn
            rd_resp_t r_pipe [1:READ_LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[1] <= w_s0;
                    for (int i = 2; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_out = r_pipe[READ_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= '0;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            if (w_out.valid)             r_rdata     <= w_out.data;
            if (w_req_ld)                r_load_cnt  <= r_load_cnt + 32'd1;
            if (w_req_st && w_in_range)  r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

    // Bypass the hold register in the valid cycle so data lines up with the pulse.
    assign bus.data_sram_rdata = w_out.valid ? w_out.data : r_rdata;
    assign bus.rdata_valid     = w_out.valid;
    assign bus.access_err      = w_out.err;
    assign bus.load_cnt        = r_load_cnt;
    assign bus.store_cnt       = r_store_cnt;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised and directed bench for data_sram_responder at READ_LATENCY=3, checked
// against a cycle-indexed model of the RAM, response schedule and counters.
module tb_data_sram_responder;
    import cpu_mem_pkg::*;

    localparam int          AW   = 10;
    localparam int          RL   = 3;
    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam int          NC   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;

    data_sram_responder_if bus();

    data_sram_responder #(
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] mem [2**AW];
    bit          ev [NC];
    bit          ee [NC];
    logic [31:0] ed [NC];
    logic [31:0] m_rdata = '0;
    logic [31:0] m_lcnt  = '0;
    logic [31:0] m_scnt  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request per cycle; the model schedules the response RL-1 edges later.
    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd);
        logic [31:0] off;
        bit          inr;
        int          idx;
        int          k;
        k = cyc;
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wd;
        if (en) begin
            off = addr - BASE;
            inr = (off < (32'd4 << AW));
            idx = int'(off >> 2);
            if (we != 4'h0) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
                    m_scnt++;
                end else begin
                    ee[k+RL-1] = 1'b1;
                end
            end else begin
                m_lcnt++;
                ev[k+RL-1] = 1'b1;
                ee[k+RL-1] = !inr;
                ed[k+RL-1] = inr ? mem[idx] : 32'h0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (ev[k]) m_rdata = ed[k];
        chk($sformatf("c%0d rdata_valid", k), {31'b0, bus.rdata_valid}, {31'b0, ev[k]});
        chk($sformatf("c%0d access_err", k),  {31'b0, bus.access_err},  {31'b0, ee[k]});
        chk($sformatf("c%0d rdata", k),       bus.data_sram_rdata, m_rdata);
        chk($sformatf("c%0d load_cnt", k),    bus.load_cnt,  m_lcnt);
        chk($sformatf("c%0d store_cnt", k),   bus.store_cnt, m_scnt);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_sram_en = 1'b0;
        bus.data_sram_we = 4'h0;
        for (int i = cyc; i < cyc + RL + 4; i++) begin
            ev[i] = 1'b0;
            ee[i] = 1'b0;
        end
        m_rdata = '0;
        m_lcnt  = '0;
        m_scnt  = '0;
        #1;
        chk("rst rdata_valid", {31'b0, bus.rdata_valid}, 32'h0);
        chk("rst access_err",  {31'b0, bus.access_err},  32'h0);
        chk("rst rdata",       bus.data_sram_rdata, 32'h0);
        chk("rst load_cnt",    bus.load_cnt,  32'h0);
        chk("rst store_cnt",   bus.store_cnt, 32'h0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_we;
        logic [31:0] r_addr;
        int          sel;

        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;
        @(negedge clk);
        do_reset();

        // full-word store then load of the same word
        step(1'b1, 4'hf, BASE + 32'd8, 32'hdead_beef);
        step(1'b1, 4'h0, BASE + 32'd8, 32'h0);
        idle(RL);
        chk("t1 rdata",     bus.data_sram_rdata, 32'hdead_beef);
        chk("t1 store_cnt", bus.store_cnt, 32'd1);
        chk("t1 load_cnt",  bus.load_cnt,  32'd1);

        // partial byte strobes
        step(1'b1, 4'hf,    BASE + 32'd20, 32'h1122_3344);
        step(1'b1, 4'b0101, BASE + 32'd20, 32'haabb_ccdd);
        step(1'b1, 4'h0,    BASE + 32'd20, 32'h0);
        idle(RL);
        chk("strobe rdata", bus.data_sram_rdata, 32'h11bb_33dd);

        // back-to-back loads fill the pipeline
        for (int i = 0; i < 4; i++) step(1'b1, 4'hf, BASE + 32'(4*i), 32'(i));
        for (int i = 0; i < 4; i++) step(1'b1, 4'h0, BASE + 32'(4*i), 32'h0);
        idle(RL + 1);

        // out-of-range load just below the base
        step(1'b1, 4'h0, BASE - 32'd4, 32'h0);
        idle(RL - 1);
        chk("oob ld valid", {31'b0, bus.rdata_valid}, 32'd1);
        chk("oob ld err",   {31'b0, bus.access_err},  32'd1);
        chk("oob ld rdata", bus.data_sram_rdata, 32'h0);
        idle(1);

        // out-of-range store one past the top must not alias word 0
        step(1'b1, 4'hf, BASE + (32'd4 << AW), 32'hffff_ffff);
        idle(RL - 1);
        chk("oob st err", {31'b0, bus.access_err}, 32'd1);
        step(1'b1, 4'h0, BASE, 32'h0);
        idle(RL);
        chk("oob st word0", bus.data_sram_rdata, 32'h0);

        // reset while a load is in flight
        step(1'b1, 4'h0, BASE + 32'd8, 32'h0);
        do_reset();
        idle(RL + 2);
        chk("midrst rdata", bus.data_sram_rdata, 32'h0);

        // load counter wrap
        force dut.r_load_cnt = 32'hffff_ffff;
        #1;
        release dut.r_load_cnt;
        m_lcnt = 32'hffff_ffff;
        chk("wrap preset", bus.load_cnt, 32'hffff_ffff);
        step(1'b1, 4'h0, BASE + 32'd4, 32'h0);
        chk("wrap load_cnt", bus.load_cnt, 32'h0);
        idle(RL);

        // random traffic over a known-initialised window plus the top word
        for (int i = 0; i < 16; i++) step(1'b1, 4'hf, BASE + 32'(4*i), $urandom);
        step(1'b1, 4'hf, BASE + 32'h0ffc, $urandom);
        for (int n = 0; n < 300; n++) begin
            r_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            sel  = $urandom_range(0, 19);
            if (sel < 16)       r_addr = BASE + 32'(4*sel) + 32'($urandom_range(0, 3));
            else if (sel == 16) r_addr = BASE + 32'h0ffc;
            else if (sel == 17) r_addr = BASE - 32'(4*$urandom_range(1, 4));
            else if (sel == 18) r_addr = BASE + 32'h1000 + 32'(4*$urandom_range(0, 7));
            else                r_addr = $urandom | 32'h8000_0000;
            step($urandom_range(0, 99) < 85, r_we, r_addr, $urandom);
        end
        idle(RL + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
